// File: rtl/full_subtractor_unit.sv
// Registered WIDTH-bit ripple-borrow subtractor: {borrow,diff} = a - b - bin.
// A chain of 1-bit full-subtractor cells feeds a result register with a valid flag.
module full_subtractor_unit #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH:0]   br;
  logic [WIDTH-1:0] d;

  assign br[0] = bin;

  // Each cell: difference bit plus borrow into the next more-significant cell.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign d[i]    = a[i] ^ b[i] ^ br[i];
    assign br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      // Without in_valid the result register holds, so idle operands never leak through.
      if (in_valid) begin
        diff   <= d;
        borrow <= br[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_full_subtractor_unit.sv
// Scoreboard bench for full_subtractor_unit: a WIDTH=1 and a WIDTH=8 instance
// share clock and reset; stimulus pushes expected results, monitors pop and compare.
module tb_full_subtractor_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       iv1 = 1'b0, a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0;
  logic       ov1, d1, bo1;
  logic       iv8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ov8, bo8;
  logic [7:0] d8;

  int ncmp = 0;
  int nerr = 0;

  logic [1:0] q1[$];   // {borrow,diff}
  logic [8:0] q8[$];

  always #5 clk = ~clk;

  full_subtractor_unit #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1), .bin(bin1),
    .out_valid(ov1), .diff(d1), .borrow(bo1)
  );

  full_subtractor_unit #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .a(a8), .b(b8), .bin(bin8),
    .out_valid(ov8), .diff(d8), .borrow(bo8)
  );

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: every presented result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (ov1 === 1'b1) begin
      if (q1.size() == 0) chk("w1_unexpected_valid", 9'd1, 9'd0);
      else chk("w1_result", {7'd0, bo1, d1}, {7'd0, q1.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (ov8 === 1'b1) begin
      if (q8.size() == 0) chk("w8_unexpected_valid", 9'd1, 9'd0);
      else chk("w8_result", {bo8, d8}, q8.pop_front());
    end
  end

  task automatic issue1(input logic a, input logic b, input logic bi,
                        input logic ed, input logic eb);
    @(negedge clk);
    iv1 = 1'b1; a1 = a; b1 = b; bin1 = bi;
    q1.push_back({eb, ed});
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        input logic [7:0] ed, input logic eb);
    @(negedge clk);
    iv8 = 1'b1; a8 = a; b8 = b; bin8 = bi;
    q8.push_back({eb, ed});
  endtask

  task automatic idle;
    @(negedge clk);
    iv1 = 1'b0; iv8 = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  // Hand-computed WIDTH=1 table, index {a,b,bin}: value {diff,borrow}.
  logic [1:0] tbl1 [8];

  initial begin
    logic [7:0] ra, rb;
    logic       rbi;
    logic [8:0] m;

    tbl1[3'b000] = 2'b00; tbl1[3'b100] = 2'b10;
    tbl1[3'b010] = 2'b11; tbl1[3'b110] = 2'b00;
    tbl1[3'b001] = 2'b11; tbl1[3'b101] = 2'b00;
    tbl1[3'b011] = 2'b01; tbl1[3'b111] = 2'b11;

    // Reset state
    #3;
    chk("reset_w1", {6'd0, ov1, bo1, d1}, 9'd0);
    chk("reset_w8", {ov8, d8}, 9'd0);
    chk("reset_w8_borrow", {8'd0, bo8}, 9'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 exhaustive, back-to-back
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = i[2:0];
      issue1(v[2], v[1], v[0], tbl1[v][1], tbl1[v][0]);
    end
    idle();

    // Mid-cycle reset after a=0,b=1 result
    issue1(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle();                       // monitor checks the 0-1 result at this negedge
    #2 rst_n = 1'b0;
    #1 chk("async_reset_w1", {6'd0, ov1, bo1, d1}, 9'd0);
    @(negedge clk);
    chk("reset_held_w1", {6'd0, ov1, bo1, d1}, 9'd0);
    rst_n = 1'b1;
    issue1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();

    // Hold: load 1-1-1, then idle with changing operands
    issue1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    idle();
    for (int i = 0; i < 3; i++) begin
      a1 = 1'($urandom); b1 = 1'($urandom); bin1 = 1'($urandom);
      @(negedge clk);
      chk("hold_w1", {6'd0, ov1, bo1, d1}, 9'b0_0000_0011);
    end

    // WIDTH=8 directed
    issue8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
    issue8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
    issue8(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1);
    issue8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
    issue8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);
    issue8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    issue8(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0);
    issue8(8'h40, 8'h40, 1'b0, 8'h00, 1'b0);
    idle();
    @(negedge clk);
    chk("w8_idle_valid", {8'd0, ov8}, 9'd0);
    chk("w8_hold", {bo8, d8}, 9'h000);

    // WIDTH=8 back-to-back random against the arithmetic reference
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
      m  = {1'b0, ra} - {1'b0, rb} - {8'd0, rbi};
      issue8(ra, rb, rbi, m[7:0], m[8]);
    end
    idle();
    repeat (3) @(negedge clk);

    chk("w1_queue_drained", 9'(q1.size()), 9'd0);
    chk("w8_queue_drained", 9'(q8.size()), 9'd0);

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

endmodule
